aes_round_sched: RTL

Iterative round scheduler for AES-128 encryption. It accepts a 128-bit plaintext block through a valid/ready handshake and fetches round keys 0..NR from the key-schedule RAM. It drives the shared single-round datapath (AddRoundKey-only, full round, or final round) once per round, capturing each result into its state register. It sits between the HPS-facing input buffer and the round datapath, and returns the ciphertext through a second valid/ready handshake.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_sched_wdog.sv | 47 ++++
 rtl/aes_round_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES scheduler types: block width, datapath round modes and scheduler FSM states.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        DP_ARK   = 2'd0,
        DP_FULL  = 2'd1,
        DP_FINAL = 2'd2
    } dp_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/aes_sched_wdog.sv
// WAIT-state watchdog for aes_round_sched: cycle counter plus sticky error flag.
// Only compiled when AES_ROUND_SCHED_WDOG_EN is defined.
`ifdef AES_ROUND_SCHED_WDOG_EN
module aes_sched_wdog #(
    parameter int WDOG_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enter_i,
    input  logic in_wait_i,
    input  logic resp_i,
    output logic timeout_o,
    output logic err_o
);

    localparam int CW = $clog2(WDOG_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Fires on the WDOG_CYC-th WAIT cycle that still has no response.
    assign timeout_o = in_wait_i && !resp_i && (cnt_q == CW'(WDOG_CYC - 1));
    assign err_o     = err_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (enter_i)
            cnt_d = '0;
        else if (in_wait_i && !resp_i)
            cnt_d = cnt_q + 1'b1;
        if (timeout_o || (resp_i && !in_wait_i))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule
`endif

// File: rtl/aes_round_sched.sv
// Iterative AES-128 round scheduler: FETCH key, ISSUE to shared round datapath, WAIT for result.
// Optional WAIT watchdog enabled by AES_ROUND_SCHED_WDOG_EN.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NR       = 10,
    parameter int KEY_AW   = 4,
    parameter int WDOG_CYC = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_block,
    output logic                 rk_rd,
    output logic [KEY_AW-1:0]    rk_addr,
    input  logic [AES_BLK_W-1:0] rk_data,
    output logic                 dp_valid,
    output logic [1:0]           dp_mode,
    output logic [AES_BLK_W-1:0] dp_state_in,
    output logic [AES_BLK_W-1:0] dp_key,
    input  logic                 dp_out_valid,
    input  logic [AES_BLK_W-1:0] dp_state_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_block,
    output logic                 busy,
    output logic [KEY_AW-1:0]    round_cnt,
    output logic                 err
);

    localparam logic [KEY_AW-1:0] R_LAST = KEY_AW'(NR);

    if (WDOG_CYC < 1 || (2 ** KEY_AW) <= NR) begin : g_cfg_chk
        $error("aes_round_sched: KEY_AW too small for NR or WDOG_CYC < 1");
    end

    sched_state_t          state_q, state_d;
    logic [KEY_AW-1:0]     r_q, r_d;
    logic [AES_BLK_W-1:0]  st_q, st_d;
    logic [AES_BLK_W-1:0]  key_q, key_d;
    logic                  wdog_to;
    dp_mode_t              mode;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        st_d    = st_q;
        key_d   = key_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                st_d    = in_block;
                r_d     = '0;
                state_d = FETCH;
            end
            FETCH: state_d = ISSUE;
            ISSUE: begin
                // Hold the key so dp_key stays stable through WAIT.
                key_d   = rk_data;
                state_d = WAIT;
            end
            WAIT: if (dp_out_valid) begin
                st_d = dp_state_out;
                if (r_q == R_LAST) begin
                    state_d = DONE;
                end else begin
                    r_d     = r_q + 1'b1;
                    state_d = FETCH;
                end
            end else if (wdog_to) begin
                state_d = IDLE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            st_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            st_q    <= st_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        mode = DP_FULL;
        if (r_q == '0)
            mode = DP_ARK;
        else if (r_q == R_LAST)
            mode = DP_FINAL;
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rk_rd       = (state_q == FETCH);
    assign rk_addr     = r_q;
    assign round_cnt   = r_q;
    assign dp_valid    = (state_q == ISSUE);
    assign dp_mode     = mode;
    assign dp_state_in = st_q;
    assign dp_key      = (state_q == ISSUE) ? rk_data : key_q;
    assign out_valid   = (state_q == DONE);
    assign out_block   = (state_q == DONE) ? st_q : '0;

`ifdef AES_ROUND_SCHED_WDOG_EN
    aes_sched_wdog #(.WDOG_CYC(WDOG_CYC)) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .enter_i   (state_q == ISSUE),
        .in_wait_i (state_q == WAIT),
        .resp_i    (dp_out_valid),
        .timeout_o (wdog_to),
        .err_o     (err)
    );
`else
    assign wdog_to = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
